// File: rtl/seq_detect_param.sv
// seq_detect_param: parametrised serial sequence detector.
// Shifts accepted bits into a PAT_W-deep history, compares it against a
// runtime-loadable pattern with per-bit don't-care mask, and emits a
// registered one-cycle match pulse plus a saturating match counter.
// Overlapping or non-overlapping detection is chosen per accepted bit.
module seq_detect_param #(
    parameter int                 PAT_W   = 4,
    parameter logic [PAT_W-1:0]   PATTERN = 4'b1010,
    parameter int                 CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in,
    input  logic              in_valid,
    input  logic              overlap_en,
    input  logic              pat_ld,
    input  logic [PAT_W-1:0]  pat_in,
    input  logic [PAT_W-1:0]  mask_in,
    input  logic              cnt_clr,
    output logic              out,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              cnt_sat,
    output logic              armed
);

    localparam int               FILL_W   = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

    typedef enum logic {
        S_FILL  = 1'b0,
        S_ARMED = 1'b1
    } state_t;

    // Saturating increment of the match counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (c == {CNT_W{1'b1}}) begin
            return c;
        end
        return c + 1'b1;
    endfunction

    // Saturating increment of the fill level, capped at PAT_W.
    function automatic logic [FILL_W-1:0] fill_inc(input logic [FILL_W-1:0] f);
        if (f == FILL_MAX) begin
            return f;
        end
        return f + 1'b1;
    endfunction

    // Masked compare: a mask bit of 0 turns that position into don't-care.
    function automatic logic pat_hit(input logic [PAT_W-1:0] h,
                                     input logic [PAT_W-1:0] p,
                                     input logic [PAT_W-1:0] m);
        return ((h ^ p) & m) == '0;
    endfunction

    state_t             state_q, state_d;
    logic [PAT_W-1:0]   hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [PAT_W-1:0]   mask_q, mask_d;
    logic               out_q, out_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sat_q, sat_d;

    logic               accept;
    logic [PAT_W-1:0]   hist_shift;
    logic [FILL_W-1:0]  fill_next;
    logic               match;

    // Window update for the candidate bit; pat_ld drops any concurrent bit.
    always_comb begin
        accept     = in_valid & ~pat_ld;
        hist_shift = {hist_q[PAT_W-2:0], in};
        fill_next  = fill_inc(fill_q);
        match      = accept && (fill_next == FILL_MAX) &&
                     pat_hit(hist_shift, pat_q, mask_q);
    end

    // Next-state logic: history/fill, pattern load, pulse and counter.
    always_comb begin
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        mask_d  = mask_q;
        out_d   = 1'b0;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        state_d = state_q;

        if (pat_ld) begin
            pat_d  = pat_in;
            mask_d = mask_in;
            hist_d = '0;
            fill_d = '0;
        end else if (accept) begin
            out_d = match;
            if (match && !overlap_en) begin
                // Non-overlapping: the next match needs a full fresh window.
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = hist_shift;
                fill_d = fill_next;
            end
        end

        // Clear wins over a same-cycle match; the pulse still fires.
        if (cnt_clr) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end else if (match) begin
            cnt_d = sat_inc(cnt_q);
            if (cnt_d == {CNT_W{1'b1}}) begin
                sat_d = 1'b1;
            end
        end

        state_d = (fill_d == FILL_MAX) ? S_ARMED : S_FILL;
    end

    // State register; reset restores the default pattern and clears all.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FILL;
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= PATTERN;
            mask_q  <= '1;
            out_q   <= 1'b0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            mask_q  <= mask_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end

    assign out       = out_q;
    assign match_cnt = cnt_q;
    assign cnt_sat   = sat_q;
    assign armed     = (state_q == S_ARMED);

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed self-checking bench for seq_detect_param (PAT_W=4, CNT_W=2).
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in = 1'b0;
    logic       in_valid = 1'b0;
    logic       overlap_en = 1'b1;
    logic       pat_ld = 1'b0;
    logic [3:0] pat_in = 4'b0;
    logic [3:0] mask_in = 4'b0;
    logic       cnt_clr = 1'b0;
    logic       out;
    logic [1:0] match_cnt;
    logic       cnt_sat;
    logic       armed;

    int checks = 0;
    int errors = 0;

    seq_detect_param #(.PAT_W(4), .PATTERN(4'b1010), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid),
        .overlap_en(overlap_en), .pat_ld(pat_ld), .pat_in(pat_in),
        .mask_in(mask_in), .cnt_clr(cnt_clr), .out(out),
        .match_cnt(match_cnt), .cnt_sat(cnt_sat), .armed(armed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // One cycle with a given bit/valid, then check the match pulse.
    task automatic step(input logic b, input logic v, input logic exp_out, input string tag);
        in = b;
        in_valid = v;
        tick();
        in_valid = 1'b0;
        chk(tag, {31'b0, out}, {31'b0, exp_out});
    endtask

    task automatic load(input logic [3:0] p, input logic [3:0] m, input logic v, input logic b);
        pat_ld = 1'b1;
        pat_in = p;
        mask_in = m;
        in_valid = v;
        in = b;
        tick();
        pat_ld = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_out", {31'b0, out}, 32'd0);
        chk("rst_cnt", {30'b0, match_cnt}, 32'd0);
        chk("rst_sat", {31'b0, cnt_sat}, 32'd0);
        chk("rst_armed", {31'b0, armed}, 32'd0);

        // Overlapping detection of 1010 in 101010
        overlap_en = 1'b1;
        step(1, 1, 0, "ov_b1");
        step(0, 1, 0, "ov_b2");
        step(1, 1, 0, "ov_b3");
        chk("ov_armed3", {31'b0, armed}, 32'd0);
        step(0, 1, 1, "ov_b4");
        chk("ov_armed4", {31'b0, armed}, 32'd1);
        step(1, 1, 0, "ov_b5");
        step(0, 1, 1, "ov_b6");
        chk("ov_cnt", {30'b0, match_cnt}, 32'd2);

        // Non-overlapping: only one match, window restarts
        do_reset();
        overlap_en = 1'b0;
        step(1, 1, 0, "no_b1");
        step(0, 1, 0, "no_b2");
        step(1, 1, 0, "no_b3");
        step(0, 1, 1, "no_b4");
        chk("no_armed", {31'b0, armed}, 32'd0);
        step(1, 1, 0, "no_b5");
        step(0, 1, 0, "no_b6");
        chk("no_cnt", {30'b0, match_cnt}, 32'd1);

        // in_valid gaps stretch the window
        do_reset();
        overlap_en = 1'b1;
        step(1, 1, 0, "gap_b1");
        step(0, 1, 0, "gap_b2");
        step(1, 0, 0, "gap_idle1");
        step(0, 0, 0, "gap_idle2");
        step(1, 0, 0, "gap_idle3");
        step(1, 1, 0, "gap_b3");
        step(0, 1, 1, "gap_b4");
        step(0, 0, 0, "gap_after");

        // Runtime pattern 1100 with bit 1 don't-care
        load(4'b1100, 4'b1101, 1'b0, 1'b0);
        chk("ld_armed", {31'b0, armed}, 32'd0);
        overlap_en = 1'b0;
        step(1, 1, 0, "msk_a1");
        step(1, 1, 0, "msk_a2");
        step(1, 1, 0, "msk_a3");
        step(0, 1, 1, "msk_a4");
        step(1, 1, 0, "msk_b1");
        step(1, 1, 0, "msk_b2");
        step(0, 1, 0, "msk_b3");
        step(1, 1, 0, "msk_b4");

        // Mid-stream reset discards history and restores PATTERN/mask
        overlap_en = 1'b1;
        step(1, 1, 0, "mr_b1");
        step(0, 1, 0, "mr_b2");
        step(1, 1, 0, "mr_b3");
        in = 1'b0;
        in_valid = 1'b1;
        do_reset();
        in_valid = 1'b0;
        chk("mr_armed", {31'b0, armed}, 32'd0);
        chk("mr_cnt", {30'b0, match_cnt}, 32'd0);
        step(0, 1, 0, "mr_c1");
        step(1, 1, 0, "mr_c2");
        step(0, 1, 0, "mr_c3");
        chk("mr_armed3", {31'b0, armed}, 32'd0);
        step(1, 1, 0, "mr_c4");
        step(0, 1, 1, "mr_c5_pat");

        // pat_ld drops a concurrent valid bit
        load(4'b1010, 4'b1111, 1'b1, 1'b1);
        chk("drop_out", {31'b0, out}, 32'd0);
        chk("drop_armed", {31'b0, armed}, 32'd0);
        step(0, 1, 0, "drop_b1");
        step(1, 1, 0, "drop_b2");
        step(0, 1, 0, "drop_b3");
        chk("drop_armed3", {31'b0, armed}, 32'd0);
        step(1, 1, 0, "drop_b4");

        // Saturation with mask all-zero, then clear racing a match
        do_reset();
        load(4'b1111, 4'b0000, 1'b0, 1'b0);
        overlap_en = 1'b1;
        step(0, 1, 0, "sat_f1");
        step(1, 1, 0, "sat_f2");
        step(1, 1, 0, "sat_f3");
        step(0, 1, 1, "sat_f4");
        chk("sat_cnt1", {30'b0, match_cnt}, 32'd1);
        step(1, 1, 1, "sat_m2");
        chk("sat_cnt2", {30'b0, match_cnt}, 32'd2);
        chk("sat_flag2", {31'b0, cnt_sat}, 32'd0);
        step(0, 1, 1, "sat_m3");
        chk("sat_cnt3", {30'b0, match_cnt}, 32'd3);
        chk("sat_flag3", {31'b0, cnt_sat}, 32'd1);
        step(1, 1, 1, "sat_m4");
        step(1, 1, 1, "sat_m5");
        step(0, 1, 1, "sat_m6");
        chk("sat_hold", {30'b0, match_cnt}, 32'd3);
        chk("sat_sticky", {31'b0, cnt_sat}, 32'd1);
        cnt_clr = 1'b1;
        step(1, 1, 1, "clr_out");
        cnt_clr = 1'b0;
        chk("clr_cnt", {30'b0, match_cnt}, 32'd0);
        chk("clr_sat", {31'b0, cnt_sat}, 32'd0);
        step(0, 1, 1, "post_clr");
        chk("post_clr_cnt", {30'b0, match_cnt}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised serial sequence detector. It samples a 1-bit serial stream on qualified cycles and compares the most recent PAT_W accepted bits against a pattern. The pattern is reset-loaded from a parameter, can be reloaded at run time, and supports per-bit don't-care masking. Each match raises a registered one-cycle pulse and bumps a saturating match counter; overlapping or non-overlapping detection is selected at run time. It is the generalised successor to the fixed 4-bit Moore detectors in the sequence-detector library.

## Interface
- PAT_W, 4, pattern length in bits (legal range 2..32)
- PATTERN, 4'b1010, reset value of the pattern register; MSB is the oldest bit
- CNT_W, 8, match counter width (legal range ≥ 1)
- clk  input  1  single clock; all state changes on the rising edge
- rst  input  1  synchronous, active-high reset
- in  input  1  serial data bit
- in_valid  input  1  `in` is accepted on a rising edge only when in_valid = 1
- overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping; sampled on every accepted bit
- pat_ld  input  1  load pat_in/mask_in into the pattern and mask registers
- pat_in  input  PAT_W  new pattern, MSB oldest
- mask_in  input  PAT_W  compare mask; bit = 1 means compare, 0 means don't-care
- cnt_clr  input  1  clear match_cnt and cnt_sat
- out  output  1  registered match pulse
- match_cnt  output  CNT_W  number of matches, saturating
- cnt_sat  output  1  sticky flag; set when match_cnt reaches all-ones
- armed  output  1  1 when the history holds PAT_W valid bits (state ARMED)

## Operation
- Registers:
  - hist[PAT_W-1:0]: shift history; new bit enters at the LSB
  - fill: 0..PAT_W, saturating
  - pat and mask
  - out, match_cnt, cnt_sat
- States, decoded from fill:
  - FILL when fill < PAT_W
  - ARMED when fill == PAT_W
- Accepted bit (in_valid=1, pat_ld=0):
  - hist_n = {hist[PAT_W-2:0], in}
  - fill_n = min(fill+1, PAT_W)
  - match = (fill_n == PAT_W) && (((hist_n ^ pat) & mask) == 0)
- On match:
  - out <= 1
  - match_cnt increments, saturating at 2^CNT_W-1
  - cnt_sat sets when match_cnt reaches all-ones
  - overlap_en=1: fill stays PAT_W, so history bits are reused
  - overlap_en=0: fill <= 0 and hist <= 0, so the next match needs PAT_W fresh bits
- No accepted bit:
  - hist and fill hold
  - out <= 0
- pat_ld=1:
  - pat <= pat_in, mask <= mask_in
  - hist <= 0, fill <= 0, out <= 0
  - a concurrent in_valid bit is dropped
  - match_cnt is unaffected
- mask_in all-zero is legal: every accepted bit in ARMED matches.
- cnt_clr=1: match_cnt <= 0 and cnt_sat <= 0. A match in the same cycle still pulses out but is not counted (clear wins).
- rst=1 has priority over everything:
  - pat <= PATTERN, mask <= all-ones
  - hist <= 0, fill <= 0
  - out <= 0, match_cnt <= 0, cnt_sat <= 0, armed <= 0
  - Mid-stream reset discards partial history; bits accepted on the reset edge are ignored.

## Timing
- Latency: out is high in the cycle immediately after the edge that accepted the completing bit, for exactly one cycle.
- match_cnt and cnt_sat update on the same edge as out.
- armed reflects fill after the edge.
- Back-to-back overlapping matches on consecutive accepted bits give out high on consecutive cycles.
- in_valid gaps stretch the detection window without breaking it; history is retained across gaps.
- pat_ld takes effect on its edge; the first accepted bit after it is bit 1 of a fresh window.
- Combinational path is limited to the PAT_W-wide XOR/AND/reduce compare feeding the out, fill and counter flops. No combinational input-to-output path.

## Test plan
- Reset value, overlap_en=1, stream 1,0,1,0,1,0 on consecutive cycles -> out pulses after the 4th and 6th bits; match_cnt=2.
- Same stream with overlap_en=0 -> single pulse after the 4th bit; match_cnt=1; armed=0 on the cycle after the match.
- Stream 1,0,1,0 with in_valid low for 3 cycles between bits 2 and 3 -> one pulse after bit 4; out stays 0 during the gaps.
- pat_ld with pat_in=4'b1100, mask_in=4'b1101, then stream 1,1,1,0 -> match (bit 1 don't-care); stream 1,1,0,1 -> no match.
- CNT_W=2, overlap on, pattern 4'b1111 with mask 0 after 4 fill bits, then 5 more accepted bits -> match_cnt sticks at 3, cnt_sat=1; cnt_clr in the same cycle as a match -> out=1, match_cnt=0.
- rst asserted after bits 1,0,1 of 1010, then 0,1,0 -> no pulse; fill restarts from 0 and pat=PATTERN; pat_ld together with in_valid -> that bit is dropped and fill=0.
